// File: rtl/hist_calc_if.sv
// hist_calc_if: host-side bin readout bus of hist_calc.
//   hist_bin_data    bin count being presented
//   hist_bin_idx     bin index being presented
//   hist_bin_ready   data/idx valid, waiting for the host
//   hist_bin_saved   host has stored the current bin (1-cycle pulse)
//   hist_frame_done  1-cycle pulse after the last bin is accepted
// master = histogram block, slave = host.
interface hist_calc_if #(
  parameter int unsigned COLORDEPTH = 8,
  parameter int unsigned BIN_WIDTH  = 16
) ();
  logic [BIN_WIDTH-1:0]  hist_bin_data;
  logic [COLORDEPTH-1:0] hist_bin_idx;
  logic                  hist_bin_ready;
  logic                  hist_bin_saved;
  logic                  hist_frame_done;

  modport master (
    output hist_bin_data, hist_bin_idx, hist_bin_ready, hist_frame_done,
    input  hist_bin_saved
  );

  modport slave (
    input  hist_bin_data, hist_bin_idx, hist_bin_ready, hist_frame_done,
    output hist_bin_saved
  );
endinterface

// File: rtl/hist_calc.sv
// hist_calc: per-frame luma histogram with ping-pong bin banks.
// One bank accumulates the current frame (3-stage read-modify-write, 1 pixel/cycle)
// while the other is read out bin by bin to the host and cleared behind it.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   data_i      luma pixel; dv_i pixel valid; vs_i vsync (active high)
//   hist        bin readout bus (hist_calc_if master)
//   overrun_o   1-cycle pulse: frame ended while readout still busy (frames merge)
//   busy_o      initial clear of both banks in progress; pixels ignored
module hist_calc #(
  parameter int unsigned COLORDEPTH = 8,
  parameter int unsigned BIN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] data_i,
  input  logic                  dv_i,
  input  logic                  vs_i,
  hist_calc_if.master           hist,
  output logic                  overrun_o,
  output logic                  busy_o
);
  localparam int unsigned          NumBins = 2 ** COLORDEPTH;
  localparam logic [BIN_WIDTH-1:0] MaxCnt  = '1;
  localparam logic [COLORDEPTH-1:0] LastIdx = '1;

  typedef enum logic {StInit, StRun} top_st_e;
  typedef enum logic [1:0] {RdIdle, RdFetch, RdPresent, RdClear} rd_st_e;

  top_st_e top_st_q, top_st_d;
  rd_st_e  rd_st_q, rd_st_d;

  logic [BIN_WIDTH-1:0] mem0 [NumBins];
  logic [BIN_WIDTH-1:0] mem1 [NumBins];

  logic [COLORDEPTH-1:0] init_addr_q, rd_idx_q;
  logic                  acc_bank_q, vs_q, done_q, overrun_q;
  logic [1:0]            end_sr_q;
  logic                  s0_valid_q, s0_bank_q, s1_valid_q, s1_bank_q, s2_valid_q, s2_bank_q;
  logic [COLORDEPTH-1:0] s0_addr_q, s1_addr_q, s2_addr_q;
  logic [BIN_WIDTH-1:0]  acc_rdata_q, s2_data_q, rd_data_q;

  logic                  frame_end, act, swap, rd_last;
  logic [BIN_WIDTH-1:0]  acc_op, acc_new;
  logic                  we0, we1;
  logic [COLORDEPTH-1:0] wa0, wa1;
  logic [BIN_WIDTH-1:0]  wd0, wd1;

  // Frame end acts two cycles after the vsync edge so in-flight pixels land first.
  assign frame_end = vs_i && !vs_q && (top_st_q == StRun);
  assign act       = end_sr_q[1] && (top_st_q == StRun);
  assign swap      = act && (rd_st_q == RdIdle);
  assign rd_last   = (rd_idx_q == LastIdx);

  // Bypass: the previous cycle's write to the same bin is not yet visible in the RAM read.
  always_comb begin
    acc_op = acc_rdata_q;
    if (s2_valid_q && (s2_bank_q == s1_bank_q) && (s2_addr_q == s1_addr_q)) acc_op = s2_data_q;
    acc_new = (acc_op == MaxCnt) ? MaxCnt : acc_op + BIN_WIDTH'(1);
  end

  // Bank write ports; accumulation and readout always target opposite banks.
  always_comb begin
    we0 = 1'b0;
    wa0 = '0;
    wd0 = '0;
    we1 = 1'b0;
    wa1 = '0;
    wd1 = '0;
    if (top_st_q == StInit) begin
      we0 = 1'b1;
      wa0 = init_addr_q;
      we1 = 1'b1;
      wa1 = init_addr_q;
    end else begin
      if (rd_st_q == RdClear) begin
        if (acc_bank_q) begin
          we0 = 1'b1;
          wa0 = rd_idx_q;
        end else begin
          we1 = 1'b1;
          wa1 = rd_idx_q;
        end
      end
      if (s1_valid_q) begin
        if (s1_bank_q) begin
          we1 = 1'b1;
          wa1 = s1_addr_q;
          wd1 = acc_new;
        end else begin
          we0 = 1'b1;
          wa0 = s1_addr_q;
          wd0 = acc_new;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem0[wa0] <= wd0;
    if (we1) mem1[wa1] <= wd1;
    acc_rdata_q <= s0_bank_q ? mem1[s0_addr_q] : mem0[s0_addr_q];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      top_st_q    <= StInit;
      rd_st_q     <= RdIdle;
      init_addr_q <= '0;
      acc_bank_q  <= 1'b0;
      rd_idx_q    <= '0;
      rd_data_q   <= '0;
      vs_q        <= 1'b0;
      end_sr_q    <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      s0_valid_q  <= 1'b0;
      s0_bank_q   <= 1'b0;
      s0_addr_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_bank_q   <= 1'b0;
      s1_addr_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_bank_q   <= 1'b0;
      s2_addr_q   <= '0;
      s2_data_q   <= '0;
    end else begin
      top_st_q    <= top_st_d;
      rd_st_q     <= rd_st_d;
      init_addr_q <= (top_st_q == StInit) ? init_addr_q + COLORDEPTH'(1) : '0;
      vs_q        <= vs_i;
      end_sr_q    <= {end_sr_q[0], frame_end};
      s0_valid_q  <= dv_i && (top_st_q == StRun);
      s0_bank_q   <= acc_bank_q;
      s0_addr_q   <= data_i;
      s1_valid_q  <= s0_valid_q;
      s1_bank_q   <= s0_bank_q;
      s1_addr_q   <= s0_addr_q;
      s2_valid_q  <= s1_valid_q;
      s2_bank_q   <= s1_bank_q;
      s2_addr_q   <= s1_addr_q;
      s2_data_q   <= acc_new;
      done_q      <= (rd_st_q == RdClear) && rd_last;
      overrun_q   <= act && (rd_st_q != RdIdle);
      if (swap) begin
        acc_bank_q <= ~acc_bank_q;
        rd_idx_q   <= '0;
      end else if ((rd_st_q == RdClear) && !rd_last) begin
        rd_idx_q <= rd_idx_q + COLORDEPTH'(1);
      end
      if (rd_st_q == RdFetch) rd_data_q <= acc_bank_q ? mem0[rd_idx_q] : mem1[rd_idx_q];
    end
  end

  // Next-state logic
  always_comb begin
    top_st_d = top_st_q;
    rd_st_d  = rd_st_q;
    unique case (top_st_q)
      StInit:  if (init_addr_q == LastIdx) top_st_d = StRun;
      StRun:   top_st_d = StRun;
      default: top_st_d = StInit;
    endcase
    unique case (rd_st_q)
      RdIdle:    if (swap) rd_st_d = RdFetch;
      RdFetch:   rd_st_d = RdPresent;
      RdPresent: if (hist.hist_bin_saved) rd_st_d = RdClear;
      RdClear:   rd_st_d = rd_last ? RdIdle : RdFetch;
      default:   rd_st_d = RdIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o               = (top_st_q == StInit);
    overrun_o            = overrun_q;
    hist.hist_bin_ready  = (rd_st_q == RdPresent);
    hist.hist_bin_data   = rd_data_q;
    hist.hist_bin_idx    = rd_idx_q;
    hist.hist_frame_done = done_q;
  end
endmodule

// File: tb/tb_hist_calc.sv
// tb_hist_calc: scoreboard bench for hist_calc. Stimulus pushes the expected 256 bins of
// each frame into a queue; a monitor pops and compares on every accepted bin handshake.
module tb_hist_calc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = '0;
  logic       dv_i = 1'b0;
  logic       vs_i = 1'b0;
  logic       overrun_o, busy_o;

  always #5 clk = ~clk;

  hist_calc_if hist ();

  hist_calc dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .dv_i      (dv_i),
    .vs_i      (vs_i),
    .hist      (hist),
    .overrun_o (overrun_o),
    .busy_o    (busy_o)
  );

  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] data;
  } bin_t;

  bin_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   host_delay = 0;
  int   done_cnt = 0;
  int   ov_cnt = 0;
  int   last_acc_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int v);
    data_i = v[7:0];
    dv_i   = 1'b1;
    tick();
  endtask

  task automatic pix(input int v, input int n);
    for (int i = 0; i < n; i++) send(v);
    dv_i = 1'b0;
  endtask

  // Expected frame: every bin zero except up to two named bins.
  task automatic expect_frame(input int ba, input int ca, input int bb, input int cb);
    for (int i = 0; i < 256; i++) begin
      bin_t b;
      b.idx  = i[7:0];
      b.data = (i == ba) ? ca[15:0] : (i == bb) ? cb[15:0] : 16'd0;
      sb.push_back(b);
    end
  endtask

  task automatic frame_end();
    vs_i = 1'b1;
    repeat (3) tick();
    vs_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      tick();
      n++;
    end
    check("drain_bins_left", sb.size(), 0);
    repeat (4) tick();
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (!(hist.hist_bin_ready && int'(hist.hist_bin_idx) == k) && n < 5000) begin
      tick();
      n++;
    end
    check("reach_idx", int'(hist.hist_bin_idx), k);
  endtask

  task automatic do_reset();
    int n = 0;
    rst  = 1'b1;
    dv_i = 1'b0;
    vs_i = 1'b0;
    tick();
    tick();
    sb.delete();
    @(negedge clk);
    check("rst_ready", int'(hist.hist_bin_ready), 0);
    check("rst_busy", int'(busy_o), 1);
    check("rst_data", int'(hist.hist_bin_data), 0);
    check("rst_idx", int'(hist.hist_bin_idx), 0);
    check("rst_done", int'(hist.hist_frame_done), 0);
    check("rst_overrun", int'(overrun_o), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    while (n < 1000) begin
      @(negedge clk);
      if (!busy_o) break;
      n++;
    end
    check("busy_cycles", n, 256);
    tick();
  endtask

  // Host: acknowledge each presented bin after host_delay cycles.
  initial begin
    hist.hist_bin_saved = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (hist.hist_bin_ready && !hist.hist_bin_saved) begin
        if (host_delay > 0) begin
          repeat (host_delay) @(posedge clk);
          #2;
        end
        hist.hist_bin_saved = 1'b1;
      end else begin
        hist.hist_bin_saved = 1'b0;
      end
    end
  end

  // Monitor: compare each accepted bin against the scoreboard.
  initial begin
    int          ready_cycles = 0;
    logic [7:0]  hold_idx = '0;
    logic [15:0] hold_data = '0;
    bin_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_cycles = 0;
      end else begin
        if (hist.hist_frame_done) begin
          done_cnt++;
          check("done_after_last_bin", last_acc_idx, 255);
        end
        if (overrun_o) ov_cnt++;
        if (hist.hist_bin_ready) begin
          if (ready_cycles == 0) begin
            hold_idx  = hist.hist_bin_idx;
            hold_data = hist.hist_bin_data;
          end
          if (hist.hist_bin_saved) begin
            if (ready_cycles > 0) begin
              check("stable_idx", int'(hist.hist_bin_idx), int'(hold_idx));
              check("stable_data", int'(hist.hist_bin_data), int'(hold_data));
            end
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_bin idx=%0d data=%0d required=none",
                       hist.hist_bin_idx, hist.hist_bin_data);
            end else begin
              e = sb.pop_front();
              check("bin_idx", int'(hist.hist_bin_idx), int'(e.idx));
              check($sformatf("bin%0d_data", e.idx), int'(hist.hist_bin_data), int'(e.data));
            end
            last_acc_idx = int'(hist.hist_bin_idx);
            ready_cycles = 0;
          end else begin
            ready_cycles++;
          end
        end else begin
          ready_cycles = 0;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // T1: single-valued frame
    pix(37, 1600);
    expect_frame(37, 1600, -1, 0);
    frame_end();
    wait_drain();
    check("frames_done_t1", done_cnt, 1);

    // T2: back-to-back identical pixels through the bypass
    send(0);
    send(0);
    send(0);
    send(5);
    send(5);
    send(0);
    dv_i = 1'b0;
    expect_frame(0, 4, 5, 2);
    frame_end();
    wait_drain();
    check("frames_done_t2", done_cnt, 2);

    // T3: saturation
    pix(200, 70000);
    expect_frame(200, 65535, -1, 0);
    frame_end();
    wait_drain();
    check("frames_done_t3", done_cnt, 3);

    // T4: slow host; next frame accumulates during readout; cleared bank reads zero
    host_delay = 10;
    pix(10, 2);
    pix(20, 1);
    expect_frame(10, 2, 20, 1);
    frame_end();
    pix(30, 3);
    pix(10, 1);
    wait_drain();
    host_delay = 0;
    check("frames_done_t4a", done_cnt, 4);
    expect_frame(30, 3, 10, 1);
    frame_end();
    wait_drain();
    pix(99, 1);
    expect_frame(99, 1, -1, 0);
    frame_end();
    wait_drain();
    check("frames_done_t4c", done_cnt, 6);

    // T5: frame end during readout merges two frames
    pix(50, 4);
    expect_frame(50, 4, -1, 0);
    frame_end();
    wait_idx(100);
    pix(50, 2);
    pix(60, 3);
    frame_end();
    check("overrun_pulses", ov_cnt, 1);
    pix(60, 1);
    wait_drain();
    check("frames_done_t5d", done_cnt, 7);
    expect_frame(50, 2, 60, 4);
    frame_end();
    wait_drain();
    check("frames_done_t5", done_cnt, 8);
    check("overrun_pulses_end", ov_cnt, 1);

    // T6: reset mid-frame and mid-readout leaves no stale counts
    pix(70, 5);
    expect_frame(70, 5, -1, 0);
    frame_end();
    wait_idx(50);
    pix(80, 3);
    do_reset();
    pix(90, 2);
    expect_frame(90, 2, -1, 0);
    frame_end();
    wait_drain();
    check("frames_done_t6", done_cnt, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
